// File: rtl/ppcm_prog_core.sv
`default_nettype none
// ============================================================================
//  Module   : ppcm_prog_core
//  Purpose  : Programs one 32-bit word into a 16-bit Parallel PCM device as
//             two halfword program operations, polling the status register
//             between them, then returns the device to read-array mode.
//  Revision : 1.0  initial release
// ============================================================================
module ppcm_prog_core #(
    parameter int CLK_FREQ  = 100,
    parameter int ADDR_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs,
    input  logic                 we,
    input  logic [ADDR_BITS-1:2] addr,
    input  logic [31:0]          din,
    output logic                 busy,
    output logic                 ack,
    output logic                 err,
    output logic                 pcm_ce_n,
    output logic                 pcm_oe_n,
    output logic                 pcm_we_n,
    output logic                 pcm_rst_n,
    output logic [ADDR_BITS-1:1] pcm_addr,
    input  logic [15:0]          pcm_din,
    output logic [15:0]          pcm_dout,
    output logic                 pcm_doe
);

    // Cycle counts derived from the device timing in ns.
    localparam int c_COUNT_INIT    = 1 + (CLK_FREQ * 100000) / 1000;
    localparam int c_COUNT_WE      = 1 + (CLK_FREQ * 50) / 1000;
    localparam int c_COUNT_GAP     = 1 + (CLK_FREQ * 30) / 1000;
    localparam int c_COUNT_READ    = 1 + (CLK_FREQ * 115) / 1000;
    localparam int c_COUNT_TIMEOUT = 1 + (CLK_FREQ * 500000) / 1000;

    localparam int c_MAX_A   = (c_COUNT_INIT > c_COUNT_TIMEOUT) ? c_COUNT_INIT : c_COUNT_TIMEOUT;
    localparam int c_MAX_B   = (c_COUNT_WE + c_COUNT_GAP > c_COUNT_READ) ? c_COUNT_WE + c_COUNT_GAP : c_COUNT_READ;
    localparam int c_CNT_MAX = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_RD_W    = $clog2(c_COUNT_READ + 1);

    localparam logic [c_CNT_W-1:0] c_INIT_LAST  = c_CNT_W'(c_COUNT_INIT - 1);
    localparam logic [c_CNT_W-1:0] c_WE_LAST    = c_CNT_W'(c_COUNT_WE - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(c_COUNT_GAP - 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LAST = c_CNT_W'(c_COUNT_WE + c_COUNT_GAP - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST    = c_CNT_W'(c_COUNT_TIMEOUT - 1);
    localparam logic [c_RD_W-1:0]  c_READ_LAST  = c_RD_W'(c_COUNT_READ - 1);

    localparam logic [15:0] c_CMD_PROG  = 16'h0040;
    localparam logic [15:0] c_CMD_CLR   = 16'h0050;
    localparam logic [15:0] c_CMD_RDARR = 16'h00FF;

    typedef enum logic [3:0] {
        S_INIT  = 4'd0,
        S_IDLE  = 4'd1,
        S_CMD   = 4'd2,
        S_CGAP  = 4'd3,
        S_DATA  = 4'd4,
        S_DGAP  = 4'd5,
        S_POLL  = 4'd6,
        S_CLR   = 4'd7,
        S_RDARR = 4'd8,
        S_DONE  = 4'd9
    } state_t;

    state_t                r_state_q, w_state_d;
    logic [c_CNT_W-1:0]    r_cnt_q, w_cnt_d;
    logic [c_RD_W-1:0]     r_rd_cnt_q, w_rd_cnt_d;
    logic                  r_half_q, w_half_d;
    logic [ADDR_BITS-1:2]  r_addr_q, w_addr_d;
    logic [31:0]           r_din_q, w_din_d;
    logic                  r_err_q, w_err_d;
    logic                  r_busy_q, w_busy_d;
    logic                  r_ack_q, w_ack_d;
    logic                  r_ce_n_q, w_ce_n_d;
    logic                  r_oe_n_q, w_oe_n_d;
    logic                  r_we_n_q, w_we_n_d;
    logic                  r_doe_q, w_doe_d;
    logic [15:0]           r_dout_q, w_dout_d;
    logic [ADDR_BITS-1:1]  r_pcm_addr_q, w_pcm_addr_d;
    logic                  r_pcm_rst_n_q;

    // Only SR7 and the program/VPP/protect error bits matter here.
    logic w_sr_ready;
    logic w_sr_fail;
    logic w_din_unused;
    assign w_sr_ready   = pcm_din[7];
    assign w_sr_fail    = pcm_din[4] | pcm_din[3] | pcm_din[1];
    assign w_din_unused = &{1'b0, pcm_din[15:8], pcm_din[6:5], pcm_din[2], pcm_din[0]};

    // Next-state, counter and latched-request logic.
    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q + c_CNT_W'(1);
        w_rd_cnt_d   = '0;
        w_half_d     = r_half_q;
        w_addr_d     = r_addr_q;
        w_din_d      = r_din_q;
        w_err_d      = r_err_q;
        w_pcm_addr_d = r_pcm_addr_q;
        case (r_state_q)
            S_INIT: begin
                if (r_cnt_q == c_INIT_LAST) begin
                    w_state_d = S_IDLE;
                    w_cnt_d   = '0;
                end
            end
            S_IDLE: begin
                w_cnt_d = '0;
                if (cs && we) begin
                    w_addr_d     = addr;
                    w_din_d      = din;
                    w_err_d      = 1'b0;
                    w_half_d     = 1'b0;
                    w_pcm_addr_d = {addr, 1'b0};
                    w_state_d    = S_CMD;
                end
            end
            S_CMD: begin
                if (r_cnt_q == c_WE_LAST) begin
                    w_state_d = S_CGAP;
                    w_cnt_d   = '0;
                end
            end
            S_CGAP: begin
                if (r_cnt_q == c_GAP_LAST) begin
                    w_state_d = S_DATA;
                    w_cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (r_cnt_q == c_WE_LAST) begin
                    w_state_d = S_DGAP;
                    w_cnt_d   = '0;
                end
            end
            S_DGAP: begin
                if (r_cnt_q == c_GAP_LAST) begin
                    w_state_d = S_POLL;
                    w_cnt_d   = '0;
                end
            end
            S_POLL: begin
                // r_cnt_q runs as the timeout counter from poll entry;
                // r_rd_cnt_q paces the status-register reads.
                w_rd_cnt_d = r_rd_cnt_q + c_RD_W'(1);
                if (r_rd_cnt_q == c_READ_LAST) begin
                    w_rd_cnt_d = '0;
                    if (w_sr_ready) begin
                        w_cnt_d = '0;
                        if (w_sr_fail) begin
                            w_err_d   = 1'b1;
                            w_state_d = S_CLR;
                        end else if (!r_half_q) begin
                            w_half_d     = 1'b1;
                            w_pcm_addr_d = {r_addr_q, 1'b1};
                            w_state_d    = S_CMD;
                        end else begin
                            w_state_d = S_RDARR;
                        end
                    end
                end
                if (w_state_d == S_POLL && r_cnt_q == c_TO_LAST) begin
                    w_err_d   = 1'b1;
                    w_state_d = S_CLR;
                    w_cnt_d   = '0;
                end
            end
            S_CLR: begin
                if (r_cnt_q == c_PULSE_LAST) begin
                    w_state_d = S_RDARR;
                    w_cnt_d   = '0;
                end
            end
            S_RDARR: begin
                if (r_cnt_q == c_PULSE_LAST) begin
                    w_state_d = S_DONE;
                    w_cnt_d   = '0;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
                w_cnt_d   = '0;
            end
            default: begin
                w_state_d = S_INIT;
                w_cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    // aligned with the state it belongs to.
    always_comb begin
        w_busy_d = (w_state_d != S_IDLE);
        w_ack_d  = (w_state_d == S_DONE);
        w_ce_n_d = 1'b1;
        w_oe_n_d = 1'b1;
        w_we_n_d = 1'b1;
        w_doe_d  = 1'b0;
        w_dout_d = 16'h0000;
        case (w_state_d)
            S_CMD: begin
                w_ce_n_d = 1'b0;
                w_we_n_d = 1'b0;
                w_doe_d  = 1'b1;
                w_dout_d = c_CMD_PROG;
            end
            S_DATA: begin
                w_ce_n_d = 1'b0;
                w_we_n_d = 1'b0;
                w_doe_d  = 1'b1;
                w_dout_d = w_half_d ? w_din_d[31:16] : w_din_d[15:0];
            end
            S_CLR, S_RDARR: begin
                // First part of the state is the write pulse, the rest is the gap.
                if (w_cnt_d <= c_WE_LAST) begin
                    w_ce_n_d = 1'b0;
                    w_we_n_d = 1'b0;
                    w_doe_d  = 1'b1;
                    w_dout_d = (w_state_d == S_CLR) ? c_CMD_CLR : c_CMD_RDARR;
                end
            end
            S_POLL: begin
                w_ce_n_d = 1'b0;
                w_oe_n_d = 1'b0;
            end
            default: begin
                w_ce_n_d = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_INIT;
            r_cnt_q       <= '0;
            r_rd_cnt_q    <= '0;
            r_half_q      <= 1'b0;
            r_addr_q      <= '0;
            r_din_q       <= '0;
            r_err_q       <= 1'b0;
            r_busy_q      <= 1'b1;
            r_ack_q       <= 1'b0;
            r_ce_n_q      <= 1'b1;
            r_oe_n_q      <= 1'b1;
            r_we_n_q      <= 1'b1;
            r_doe_q       <= 1'b0;
            r_dout_q      <= '0;
            r_pcm_addr_q  <= '0;
            r_pcm_rst_n_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_rd_cnt_q    <= w_rd_cnt_d;
            r_half_q      <= w_half_d;
            r_addr_q      <= w_addr_d;
            r_din_q       <= w_din_d;
            r_err_q       <= w_err_d;
            r_busy_q      <= w_busy_d;
            r_ack_q       <= w_ack_d;
            r_ce_n_q      <= w_ce_n_d;
            r_oe_n_q      <= w_oe_n_d;
            r_we_n_q      <= w_we_n_d;
            r_doe_q       <= w_doe_d;
            r_dout_q      <= w_dout_d;
            r_pcm_addr_q  <= w_pcm_addr_d;
            r_pcm_rst_n_q <= 1'b1;
        end
    end

    assign busy      = r_busy_q;
    assign ack       = r_ack_q;
    assign err       = r_err_q;
    assign pcm_ce_n  = r_ce_n_q;
    assign pcm_oe_n  = r_oe_n_q;
    assign pcm_we_n  = r_we_n_q;
    assign pcm_rst_n = r_pcm_rst_n_q;
    assign pcm_addr  = r_pcm_addr_q;
    assign pcm_dout  = r_dout_q;
    assign pcm_doe   = r_doe_q;

endmodule
`default_nettype wire

// File: tb/tb_ppcm_prog_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ppcm_prog_core
//  Purpose  : Directed self-checking bench for ppcm_prog_core (100 MHz,
//             24-bit byte address).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ppcm_prog_core;

    logic        clk;
    logic        rst;
    logic        cs;
    logic        we;
    logic [23:2] addr;
    logic [31:0] din;
    logic        busy;
    logic        ack;
    logic        err;
    logic        pcm_ce_n;
    logic        pcm_oe_n;
    logic        pcm_we_n;
    logic        pcm_rst_n;
    logic [23:1] pcm_addr;
    logic [15:0] pcm_din;
    logic [15:0] pcm_dout;
    logic        pcm_doe;

    ppcm_prog_core #(
        .CLK_FREQ  (100),
        .ADDR_BITS (24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .we        (we),
        .addr      (addr),
        .din       (din),
        .busy      (busy),
        .ack       (ack),
        .err       (err),
        .pcm_ce_n  (pcm_ce_n),
        .pcm_oe_n  (pcm_oe_n),
        .pcm_we_n  (pcm_we_n),
        .pcm_rst_n (pcm_rst_n),
        .pcm_addr  (pcm_addr),
        .pcm_din   (pcm_din),
        .pcm_dout  (pcm_dout),
        .pcm_doe   (pcm_doe)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Bus monitor state.
    logic [15:0] wr_data [$];
    logic [23:1] wr_addr [$];
    int          wr_len  [$];
    int          ack_cnt     = 0;
    int          oe_low_cnt  = 0;
    int          overlap_cnt = 0;
    logic        prev_we_n   = 1'b1;
    int          cur_len     = 0;

    // Expected write sequence for the current operation.
    logic [15:0] exp_d [0:7];
    logic [23:1] exp_a [0:7];
    int          exp_n;

    // Records every PCM write pulse (data, address, length) and bus hazards.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_we_n = 1'b1;
                cur_len   = 0;
            end else begin
                if (!pcm_we_n && !pcm_oe_n) overlap_cnt++;
                if (pcm_doe && !pcm_oe_n)   overlap_cnt++;
                if (!pcm_oe_n)              oe_low_cnt++;
                if (ack)                    ack_cnt++;
                if (!pcm_we_n) begin
                    if (prev_we_n) begin
                        wr_data.push_back(pcm_dout);
                        wr_addr.push_back(pcm_addr);
                    end
                    cur_len++;
                end else if (!prev_we_n) begin
                    wr_len.push_back(cur_len);
                    cur_len = 0;
                end
                prev_we_n = pcm_we_n;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wr_data.delete();
        wr_addr.delete();
        wr_len.delete();
        ack_cnt    = 0;
        oe_low_cnt = 0;
    endtask

    task automatic set_exp(input int idx, input logic [15:0] d, input logic [23:1] a);
        exp_d[idx] = d;
        exp_a[idx] = a;
        exp_n      = idx + 1;
    endtask

    // Compares the recorded write pulses against exp_*; each pulse is 6 cycles.
    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, 32'(wr_data.size()), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            if (i < wr_data.size()) begin
                check($sformatf("%s_dat%0d", tag, i), 32'(wr_data[i]), 32'(exp_d[i]));
                check($sformatf("%s_adr%0d", tag, i), 32'(wr_addr[i]), 32'(exp_a[i]));
            end
            if (i < wr_len.size()) begin
                check($sformatf("%s_len%0d", tag, i), 32'(wr_len[i]), 32'd6);
            end
        end
    endtask

    // Called at a negedge with rst high: releases reset and counts busy samples,
    // firing one request partway through to show it is ignored.
    task automatic release_and_count(output int n);
        n   = 0;
        rst = 1'b0;
        while (busy === 1'b1 && n < 20000) begin
            n++;
            if (n == 100) begin
                cs = 1'b1;
                we = 1'b1;
            end else begin
                cs = 1'b0;
                we = 1'b0;
            end
            @(negedge clk);
        end
        cs = 1'b0;
        we = 1'b0;
    endtask

    // Issues a one-cycle request, then scrambles addr/din.
    task automatic start_write(input logic [23:2] a, input logic [31:0] d);
        cs   = 1'b1;
        we   = 1'b1;
        addr = a;
        din  = d;
        @(negedge clk);
        cs   = 1'b0;
        we   = 1'b0;
        addr = ~a;
        din  = ~d;
    endtask

    task automatic wait_ack(input string tag, input int bound);
        int n = 0;
        while (ack !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ack_seen"}, 32'(ack), 32'd1);
    endtask

    initial begin
        int  n;
        int  found;
        rst     = 1'b1;
        cs      = 1'b0;
        we      = 1'b0;
        addr    = '0;
        din     = '0;
        pcm_din = 16'h0000;
        exp_n   = 0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(busy),      32'd1);
        check("rst_ack",    32'(ack),       32'd0);
        check("rst_err",    32'(err),       32'd0);
        check("rst_ce_n",   32'(pcm_ce_n),  32'd1);
        check("rst_oe_n",   32'(pcm_oe_n),  32'd1);
        check("rst_we_n",   32'(pcm_we_n),  32'd1);
        check("rst_doe",    32'(pcm_doe),   32'd0);
        check("rst_dout",   32'(pcm_dout),  32'd0);
        check("rst_addr",   32'(pcm_addr),  32'd0);
        check("rst_pcmrst", 32'(pcm_rst_n), 32'd0);

        // Init delay: 1 + 100*100000/1000 = 10001 busy cycles.
        release_and_count(n);
        check("init_busy_cycles", 32'(n), 32'd10001);
        repeat (3) @(negedge clk);
        check("init_busy_low", 32'(busy),           32'd0);
        check("init_no_write", 32'(wr_data.size()), 32'd0);
        check("init_no_ack",   32'(ack_cnt),        32'd0);
        check("pcm_rst_rel",   32'(pcm_rst_n),      32'd1);

        // cs alone and we alone are ignored in idle.
        cs = 1'b1; @(negedge clk);
        cs = 1'b0; we = 1'b1; @(negedge clk);
        we = 1'b0;
        repeat (4) @(negedge clk);
        check("partial_req_busy", 32'(busy),           32'd0);
        check("partial_req_nwr",  32'(wr_data.size()), 32'd0);

        // T1: both halves succeed immediately.
        clear_mon();
        pcm_din = 16'h0080;
        start_write(22'h000010, 32'hBEEF1234);
        wait_ack("t1", 500);
        check("t1_err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        check("t1_acks", 32'(ack_cnt), 32'd1);
        check("t1_busy", 32'(busy),    32'd0);
        set_exp(0, 16'h0040, 23'h000020);
        set_exp(1, 16'h1234, 23'h000020);
        set_exp(2, 16'h0040, 23'h000021);
        set_exp(3, 16'hBEEF, 23'h000021);
        set_exp(4, 16'h00FF, 23'h000021);
        check_writes("t1");

        // T2: program error bit 4 on first poll, high half skipped.
        clear_mon();
        pcm_din = 16'h0090;
        start_write(22'h00ABCD, 32'h5555AAAA);
        wait_ack("t2", 500);
        check("t2_err", 32'(err), 32'd1);
        repeat (5) @(negedge clk);
        check("t2_err_held", 32'(err),     32'd1);
        check("t2_acks",     32'(ack_cnt), 32'd1);
        set_exp(0, 16'h0040, 23'h01579A);
        set_exp(1, 16'hAAAA, 23'h01579A);
        set_exp(2, 16'h0050, 23'h01579A);
        set_exp(3, 16'h00FF, 23'h01579A);
        check_writes("t2");

        // T2b: error bit 3; err from T2 must clear on the new request.
        clear_mon();
        pcm_din = 16'h0088;
        start_write(22'h000002, 32'h11112222);
        @(negedge clk);
        check("t2b_err_cleared", 32'(err), 32'd0);
        wait_ack("t2b", 500);
        check("t2b_err", 32'(err), 32'd1);
        repeat (3) @(negedge clk);
        set_exp(0, 16'h0040, 23'h000004);
        set_exp(1, 16'h2222, 23'h000004);
        set_exp(2, 16'h0050, 23'h000004);
        set_exp(3, 16'h00FF, 23'h000004);
        check_writes("t2b");

        // T3: SR7 never set; timeout after 50001 poll cycles, top address.
        clear_mon();
        pcm_din = 16'h0000;
        start_write(22'h3FFFFF, 32'hCAFEF00D);
        @(negedge clk);
        check("t3_err_cleared", 32'(err), 32'd0);
        wait_ack("t3", 60000);
        check("t3_err", 32'(err), 32'd1);
        repeat (3) @(negedge clk);
        check("t3_poll_cycles", 32'(oe_low_cnt), 32'd50001);
        check("t3_acks",        32'(ack_cnt),    32'd1);
        set_exp(0, 16'h0040, 23'h7FFFFE);
        set_exp(1, 16'hF00D, 23'h7FFFFE);
        set_exp(2, 16'h0050, 23'h7FFFFE);
        set_exp(3, 16'h00FF, 23'h7FFFFE);
        check_writes("t3");

        // T4: reset during the data pulse aborts with no ack.
        clear_mon();
        pcm_din = 16'h0080;
        start_write(22'h000010, 32'hBEEF1234);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (pcm_we_n === 1'b0 && pcm_dout === 16'h1234) found = 1;
            else @(negedge clk);
        end
        check("t4_data_seen", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t4_we_n_rel", 32'(pcm_we_n), 32'd1);
        check("t4_doe_rel",  32'(pcm_doe),  32'd0);
        check("t4_busy",     32'(busy),     32'd1);
        @(negedge clk);
        release_and_count(n);
        check("t4_init_cycles", 32'(n),       32'd10001);
        check("t4_no_ack",      32'(ack_cnt), 32'd0);
        repeat (2) @(negedge clk);
        clear_mon();
        start_write(22'h000010, 32'hBEEF1234);
        wait_ack("t4", 500);
        check("t4_err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        set_exp(0, 16'h0040, 23'h000020);
        set_exp(1, 16'h1234, 23'h000020);
        set_exp(2, 16'h0040, 23'h000021);
        set_exp(3, 16'hBEEF, 23'h000021);
        set_exp(4, 16'h00FF, 23'h000021);
        check_writes("t4");

        // T5: a second request while busy is dropped.
        clear_mon();
        start_write(22'h000123, 32'h87654321);
        repeat (20) @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = 22'h000200; din = 32'hFFFFFFFF;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
        wait_ack("t5", 500);
        repeat (60) @(negedge clk);
        check("t5_acks", 32'(ack_cnt), 32'd1);
        check("t5_busy", 32'(busy),    32'd0);
        set_exp(0, 16'h0040, 23'h000246);
        set_exp(1, 16'h4321, 23'h000246);
        set_exp(2, 16'h0040, 23'h000247);
        set_exp(3, 16'h8765, 23'h000247);
        set_exp(4, 16'h00FF, 23'h000247);
        check_writes("t5");

        check("bus_overlap", 32'(overlap_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
